// File: rtl/rc4_phase_ctrl_if.sv
// Bus between the RC4 phase sequencer and its three phase blocks: handshakes,
// the three S-RAM requester ports, the muxed S-RAM port and status.
interface rc4_phase_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              go;
    logic              key_fail;
    logic              init_start, ksa_start, prga_start;
    logic              init_finish, ksa_finish, prga_finish;
    logic [ADDR_W-1:0] init_addr, ksa_addr, prga_addr;
    logic [DATA_W-1:0] init_data, ksa_data, prga_data;
    logic              init_wen, ksa_wen, prga_wen;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;
    logic              s_wen;
    logic [1:0]        phase;
    logic              key_next;
    logic [3:0]        retry_cnt;
    logic              busy;
    logic              done;
    logic              error;

    // Sequencer side.
    modport slave (
        input  go, key_fail,
        input  init_finish, ksa_finish, prga_finish,
        input  init_addr, ksa_addr, prga_addr,
        input  init_data, ksa_data, prga_data,
        input  init_wen, ksa_wen, prga_wen,
        output init_start, ksa_start, prga_start,
        output s_addr, s_data, s_wen,
        output phase, key_next, retry_cnt, busy, done, error
    );

    // Phase blocks / host side.
    modport master (
        output go, key_fail,
        output init_finish, ksa_finish, prga_finish,
        output init_addr, ksa_addr, prga_addr,
        output init_data, ksa_data, prga_data,
        output init_wen, ksa_wen, prga_wen,
        input  init_start, ksa_start, prga_start,
        input  s_addr, s_data, s_wen,
        input  phase, key_next, retry_cnt, busy, done, error
    );
endinterface

// File: rtl/rc4_phase_ctrl.sv
// RC4 decrypt sequencer: runs INIT -> KSA -> PRGA, owns the S-RAM grant,
// retries with the next key on failure and enforces a per-phase watchdog.
module rc4_phase_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_RETRY = 15,
    parameter int TIMEOUT   = 4096
) (
    input  logic             clk,
    input  logic             reset,
    rc4_phase_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, INIT, KSA, PRGA, DONE, ERROR} state_t;

    localparam int         WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [1:0] PH_NONE = 2'b00;
    localparam logic [1:0] PH_INIT = 2'b01;
    localparam logic [1:0] PH_KSA  = 2'b10;
    localparam logic [1:0] PH_PRGA = 2'b11;

    state_t          state;
    logic [1:0]      phase;
    logic            init_start, ksa_start, prga_start;
    logic            key_next;
    logic [3:0]      retry_cnt;
    logic            busy, done, error;
    logic [WD_W-1:0] wdog;
    logic            wd_expire;

    // The finish check precedes wd_expire in every phase, so a finish in the
    // last allowed cycle wins over the timeout.
    assign wd_expire = (TIMEOUT != 0) && (wdog == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= PH_NONE;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
            key_next   <= 1'b0;
            retry_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            wdog       <= '0;
        end else begin
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            prga_start <= 1'b0;
            key_next   <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.go) begin
                        state      <= INIT;
                        phase      <= PH_INIT;
                        init_start <= 1'b1;
                        retry_cnt  <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        wdog       <= '0;
                    end
                end
                INIT: begin
                    if (bus.init_finish) begin
                        state     <= KSA;
                        phase     <= PH_KSA;
                        ksa_start <= 1'b1;
                        wdog      <= '0;
                    end else if (wd_expire) begin
                        state <= ERROR;
                        phase <= PH_NONE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                KSA: begin
                    if (bus.ksa_finish) begin
                        state      <= PRGA;
                        phase      <= PH_PRGA;
                        prga_start <= 1'b1;
                        wdog       <= '0;
                    end else if (wd_expire) begin
                        state <= ERROR;
                        phase <= PH_NONE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                PRGA: begin
                    if (bus.prga_finish) begin
                        if (!bus.key_fail) begin
                            state <= DONE;
                            phase <= PH_NONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (retry_cnt < RETRY_MAX) begin
                            // Re-init S and rerun the schedule with the next key.
                            state      <= INIT;
                            phase      <= PH_INIT;
                            init_start <= 1'b1;
                            key_next   <= 1'b1;
                            retry_cnt  <= retry_cnt + 1'b1;
                            wdog       <= '0;
                        end else begin
                            state <= ERROR;
                            phase <= PH_NONE;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end
                    end else if (wd_expire) begin
                        state <= ERROR;
                        phase <= PH_NONE;
                        busy  <= 1'b0;
                        error <= 1'b1;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    phase <= PH_NONE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Grant mux keys off the registered phase, so reset drops s_wen at once.
    always_comb begin
        bus.s_addr = '0;
        bus.s_data = '0;
        bus.s_wen  = 1'b0;
        case (phase)
            PH_INIT: begin
                bus.s_addr = bus.init_addr;
                bus.s_data = bus.init_data;
                bus.s_wen  = bus.init_wen;
            end
            PH_KSA: begin
                bus.s_addr = bus.ksa_addr;
                bus.s_data = bus.ksa_data;
                bus.s_wen  = bus.ksa_wen;
            end
            PH_PRGA: begin
                bus.s_addr = bus.prga_addr;
                bus.s_data = bus.prga_data;
                bus.s_wen  = bus.prga_wen;
            end
            default: ;
        endcase
    end

    assign bus.phase      = phase;
    assign bus.init_start = init_start;
    assign bus.ksa_start  = ksa_start;
    assign bus.prga_start = prga_start;
    assign bus.key_next   = key_next;
    assign bus.retry_cnt  = retry_cnt;
    assign bus.busy       = busy;
    assign bus.done       = done;
    assign bus.error      = error;
endmodule
